button_event_gen: RTL and testbench
===================================

# button_event_gen

Converts the debounced push-button level into single-clock event pulses for the alarm-clock control logic: press, release, long-press, and an auto-repeating `step` used to advance hours and minutes while a button is held. It sits directly downstream of the debouncer, one instance per button. It resynchronises the debouncer's slow-clock output into the `clock` domain. It then runs a small hold-timer state machine.

## Interface
- `LONG_CYCLES`, default 50_000_000: hold time, in `clock` cycles, before long-press (1 s at 50 MHz); legal range ≥ 2.
- `REPEAT_CYCLES`, default 10_000_000: auto-repeat period after long-press (200 ms at 50 MHz); legal range ≥ 2.
- `clock`  in  1: FPGA system clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `p_in`  in  1: debounced button level from the debouncer; asynchronous to `clock`.
- `enable`  in  1: when low, all event outputs are masked to 0; the state machine keeps running.
- `press`  out  1: one-cycle pulse on button press.
- `release`  out  1: one-cycle pulse on button release.
- `long_press`  out  1: one-cycle pulse when the hold reaches `LONG_CYCLES`.
- `step`  out  1: one-cycle pulse on press, on long-press, and on every repeat.
- `held`  out  1: level signal, high while in state HELD.

## Operation
- Synchroniser: `s1 <= p_in`, `s2 <= s1`, `s3 <= s2`.
  - Rising edge is `s2 & ~s3`; falling edge is `~s2 & s3`.
- One counter `cnt`, width `$clog2(max(LONG_CYCLES, REPEAT_CYCLES))`. It never exceeds `max - 1`, so no wrap is possible.
- State IDLE:
  - `cnt = 0`.
  - On a rising edge: go to PRESSED, assert `press` and `step`, clear `cnt`.
- State PRESSED:
  - `cnt` increments each cycle.
  - If `cnt == LONG_CYCLES - 1` and there is no falling edge: go to HELD, assert `long_press` and `step`, clear `cnt`.
- State HELD:
  - `cnt` increments each cycle.
  - If `cnt == REPEAT_CYCLES - 1` and there is no falling edge: assert `step`, clear `cnt`, stay in HELD.
- Falling edge in PRESSED or HELD:
  - Go to IDLE, assert `release`, clear `cnt`.
  - Release takes priority over a threshold match in the same cycle; `long_press` and `step` are suppressed.
- A rising and a falling edge cannot occur in the same cycle (they come from one `s2`/`s3` pair).
- All outputs are registered.
  - Event outputs are ANDed with `enable` before the output register.
  - `held` is not masked.
- Reset values:
  - `s1`, `s2`, `s3`, `cnt`, and every output are 0; state is IDLE.
  - Consequence: if the button is already held when `reset_n` deasserts, one press is reported.
- Assertion of `reset_n` mid-operation:
  - Returns immediately to IDLE with all outputs 0.
  - No `release` pulse is generated.

## Timing
- `p_in` rises with setup before edge E1:
  - `s1 = 1` after E1, `s2 = 1` after E2.
  - `press` and `step` are high between edge E3 and E4, exactly one cycle.
  - The state is PRESSED from E3.
- Falling latency is identical: `release` is high between E3 and E4 after `p_in` falls.
- Let T be the cycle in which `press` is high, with the button held:
  - `long_press` and `step` are high in cycle T + `LONG_CYCLES`.
  - `held` rises at that same cycle.
  - Repeat `step` pulses follow at T + `LONG_CYCLES` + k·`REPEAT_CYCLES`, for k ≥ 1.
- `held` falls together with the `release` pulse.
- Every event output is high for exactly one cycle; none is ever high two cycles in a row.
- A `p_in` pulse of only one `clock` cycle is still reported, as a press followed by a release one cycle later. Filtering such pulses is the debouncer's job.

## Test plan
All scenarios use `LONG_CYCLES = 10` and `REPEAT_CYCLES = 4`.
- Short press, `p_in` high for 5 cycles:
  - exactly one `press` and one `step` at T, and one `release` 5 cycles later;
  - no `long_press`, `held` stays 0.
- Hold for 25 cycles:
  - `press` and `step` at T;
  - `long_press`, `step`, and `held` rise at T+10;
  - further `step` at T+14, T+18, T+22;
  - `release` at T+25, `held` falls at T+25.
- Release timed so the falling edge lands in cycle T+9 (the `cnt == 9` match):
  - `release` only;
  - no `long_press`, no `step` at T+10; state is IDLE.
- Assert `reset_n` low at T+16 while in HELD:
  - all outputs 0 immediately and asynchronously, without waiting for a clock edge;
  - no `release`.
- Release `reset_n` with `p_in` already held: one `press` pulse 3 edges after reset release.
- Hold for 25 cycles with `enable = 0`:
  - `press`, `step`, `long_press`, and `release` all remain 0;
  - `held` still goes high at T+10;
  - re-enabling at T+20 makes the next `step` appear at T+22.

Source files
------------

// File: rtl/button_event_gen.sv
// button_event_gen: turns a debounced button level into single-cycle
// press / release / long-press / auto-repeat step events.
module button_event_gen #(
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic p_in,
    input  logic enable,
    output logic press,
    output logic released,
    output logic long_press,
    output logic step,
    output logic held
);

    localparam int MAX_CYCLES = (LONG_CYCLES > REPEAT_CYCLES) ?
                                LONG_CYCLES : REPEAT_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    logic s1;
    logic s2;
    logic s3;
    logic rise;
    logic fall;

    logic press_nxt;
    logic released_nxt;
    logic long_nxt;
    logic step_nxt;
    logic held_nxt;

    // p_in is asynchronous; s3 only serves as the edge-detect history
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= p_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        unique case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt = PRESSED;
                end
            end
            PRESSED: begin
                if (fall) begin
                    state_nxt = IDLE;
                end else if (cnt == LONG_LAST) begin
                    state_nxt = HELD;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            HELD: begin
                if (fall) begin
                    state_nxt = IDLE;
                end else if (cnt != REP_LAST) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Release wins over a threshold match landing in the same cycle
    always_comb begin
        press_nxt    = 1'b0;
        released_nxt = 1'b0;
        long_nxt     = 1'b0;
        step_nxt     = 1'b0;
        unique case (state)
            IDLE: begin
                press_nxt = rise;
                step_nxt  = rise;
            end
            PRESSED: begin
                released_nxt = fall;
                long_nxt     = ~fall & (cnt == LONG_LAST);
                step_nxt     = ~fall & (cnt == LONG_LAST);
            end
            HELD: begin
                released_nxt = fall;
                step_nxt     = ~fall & (cnt == REP_LAST);
            end
            default: begin
                released_nxt = 1'b0;
            end
        endcase
        held_nxt = (state_nxt == HELD);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            press      <= 1'b0;
            released   <= 1'b0;
            long_press <= 1'b0;
            step       <= 1'b0;
            held       <= 1'b0;
        end else begin
            press      <= press_nxt & enable;
            released   <= released_nxt & enable;
            long_press <= long_nxt & enable;
            step       <= step_nxt & enable;
            held       <= held_nxt;
        end
    end

endmodule

// File: tb/tb_button_event_gen.sv
// Bench for button_event_gen: cycle-by-cycle event model plus
// directed hold/release/reset/enable scenarios with literal timings.
module tb_button_event_gen;

    localparam int LC = 10;
    localparam int RC = 4;

    logic clock = 1'b0;
    logic reset_n;
    logic p_in;
    logic enable;
    logic press;
    logic released;
    logic long_press;
    logic step;
    logic held;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    logic smp_p  = 1'b0;
    logic smp_en = 1'b0;
    logic smp_v  = 1'b0;

    bit hq[$];
    int since = -1;

    int n_press;
    int n_rel;
    int n_long;
    int last_press;
    int last_rel;
    int last_long;
    int held_first;
    int held_last;
    int steps[$];

    button_event_gen #(
        .LONG_CYCLES(LC),
        .REPEAT_CYCLES(RC)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .p_in(p_in),
        .enable(enable),
        .press(press),
        .released(released),
        .long_press(long_press),
        .step(step),
        .held(held)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        smp_p  <= p_in;
        smp_en <= enable;
        smp_v  <= reset_n;
    end

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, act, exp);
        end
    endtask

    task automatic clr();
        n_press    = 0;
        n_rel      = 0;
        n_long     = 0;
        last_press = -1;
        last_rel   = -1;
        last_long  = -1;
        held_first = -1;
        held_last  = -1;
        steps.delete();
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    // Reference: event times derived from the level seen two cycles late
    initial begin
        bit L;
        bit Lp;
        bit e_p;
        bit e_r;
        bit e_l;
        bit e_s;
        bit e_h;
        forever begin
            @(negedge clock);
            cyc++;
            if (!reset_n) begin
                hq    = '{0, 0, 0};
                since = -1;
                chk("reset_outs",
                    int'({press, released, long_press, step, held}), 0);
            end else begin
                e_p = 0;
                e_r = 0;
                e_l = 0;
                e_s = 0;
                e_h = 0;
                if (smp_v) begin
                    hq.push_back(smp_p);
                    if (hq.size() > 8) void'(hq.pop_front());
                    L  = hq[hq.size() - 3];
                    Lp = hq[hq.size() - 4];
                    if (L && !Lp) begin
                        since = 0;
                        e_p   = 1;
                        e_s   = 1;
                    end else if (!L && Lp) begin
                        if (since >= 0) e_r = 1;
                        since = -1;
                    end else if (L && since >= 0) begin
                        since++;
                        if (since == LC) begin
                            e_l = 1;
                            e_s = 1;
                        end else if (since > LC && (since - LC) % RC == 0) begin
                            e_s = 1;
                        end
                    end
                    e_h = L && since >= LC;
                    e_p &= smp_en;
                    e_r &= smp_en;
                    e_l &= smp_en;
                    e_s &= smp_en;
                end
                chk("model_press", int'(press), int'(e_p));
                chk("model_release", int'(released), int'(e_r));
                chk("model_long", int'(long_press), int'(e_l));
                chk("model_step", int'(step), int'(e_s));
                chk("model_held", int'(held), int'(e_h));
                if (press) begin n_press++; last_press = cyc; end
                if (released) begin n_rel++; last_rel = cyc; end
                if (long_press) begin n_long++; last_long = cyc; end
                if (step) steps.push_back(cyc);
                if (held) begin
                    if (held_first < 0) held_first = cyc;
                    held_last = cyc;
                end
            end
        end
    end

    initial begin
        int c0;
        int t;
        reset_n = 1'b0;
        p_in    = 1'b0;
        enable  = 1'b1;
        tick(3);
        reset_n = 1'b1;
        tick(3);

        // short press, 5 cycles
        clr();
        c0   = cyc;
        p_in = 1'b1;
        tick(5);
        p_in = 1'b0;
        tick(8);
        chk("short_press_time", last_press, c0 + 3);
        chk("short_press_cnt", n_press, 1);
        chk("short_rel_delay", last_rel - last_press, 5);
        chk("short_long_cnt", n_long, 0);
        chk("short_step_cnt", steps.size(), 1);
        chk("short_held", held_first, -1);

        // single-cycle pulse still reported
        clr();
        c0   = cyc;
        p_in = 1'b1;
        tick(1);
        p_in = 1'b0;
        tick(6);
        chk("pulse_press", last_press, c0 + 3);
        chk("pulse_rel", last_rel, c0 + 4);

        // hold 25 cycles
        clr();
        c0   = cyc;
        t    = c0 + 3;
        p_in = 1'b1;
        tick(25);
        p_in = 1'b0;
        tick(8);
        chk("hold_press", last_press, t);
        chk("hold_long", last_long, t + 10);
        chk("hold_step_cnt", steps.size(), 5);
        if (steps.size() == 5) begin
            chk("hold_step0", steps[0], t);
            chk("hold_step1", steps[1], t + 10);
            chk("hold_step2", steps[2], t + 14);
            chk("hold_step3", steps[3], t + 18);
            chk("hold_step4", steps[4], t + 22);
        end
        chk("hold_rel", last_rel, t + 25);
        chk("hold_held_rise", held_first, t + 10);
        chk("hold_held_fall", held_last, t + 24);

        // falling edge lands on the cnt == LC-1 cycle
        clr();
        c0   = cyc;
        t    = c0 + 3;
        p_in = 1'b1;
        tick(10);
        p_in = 1'b0;
        tick(8);
        chk("edge_rel", last_rel, t + 10);
        chk("edge_long_cnt", n_long, 0);
        chk("edge_step_cnt", steps.size(), 1);
        chk("edge_held", held_first, -1);

        // reset asserted while HELD
        clr();
        c0   = cyc;
        p_in = 1'b1;
        tick(3 + 16);
        chk("rst_pre_held", int'(held), 1);
        reset_n = 1'b0;
        #1;
        chk("rst_async_outs",
            int'({press, released, long_press, step, held}), 0);
        tick(3);
        chk("rst_no_release", n_rel, 0);

        // release reset with the button already down
        clr();
        c0      = cyc;
        reset_n = 1'b1;
        tick(6);
        chk("rst_hold_press", last_press, c0 + 3);
        chk("rst_hold_press_cnt", n_press, 1);
        p_in = 1'b0;
        tick(6);

        // fully disabled hold
        clr();
        enable = 1'b0;
        c0     = cyc;
        t      = c0 + 3;
        p_in   = 1'b1;
        tick(25);
        p_in = 1'b0;
        tick(8);
        chk("dis_events",
            n_press + n_rel + n_long + steps.size(), 0);
        chk("dis_held_rise", held_first, t + 10);
        chk("dis_held_fall", held_last, t + 24);

        // disabled hold, re-enabled at T+20
        clr();
        c0   = cyc;
        t    = c0 + 3;
        p_in = 1'b1;
        tick(23);
        enable = 1'b1;
        tick(2);
        p_in = 1'b0;
        tick(8);
        chk("reen_press_cnt", n_press, 0);
        chk("reen_long_cnt", n_long, 0);
        chk("reen_step_cnt", steps.size(), 1);
        chk("reen_step_time", steps.size() > 0 ? steps[0] : -1, t + 22);
        chk("reen_rel", last_rel, t + 25);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
